// File: rtl/vid_meas_pkg.sv
// Shared types and constants for the pixel-stream frame measurement block.
package vid_meas_pkg;

    // Stream-tracking states: hunting for vblank, in vblank, in hblank, inside a line.
    typedef enum logic [1:0] {
        S_SYNC   = 2'd0,
        S_VBLANK = 2'd1,
        S_HBLANK = 2'd2,
        S_LINE   = 2'd3
    } state_t;

    // Bit positions inside the per-frame error vector.
    localparam int ERR_WIDTH = 0;   // line width differs from the first line
    localparam int ERR_DE    = 1;   // de seen outside an active line
    localparam int ERR_OVF   = 2;   // pixel or line counter saturated
    localparam int ERR_W     = 3;

endpackage

// File: rtl/vid_stream_meas.sv
// Frame measurement on a di/de/hs/vs pixel stream: reports width, height,
// checksum and protocol errors once per frame with a one-cycle done pulse.
module vid_stream_meas
    import vid_meas_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16,
    parameter int SUM_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] di_i,
    input  logic                  de_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [CNT_WIDTH-1:0]  width_o,
    output logic [CNT_WIDTH-1:0]  height_o,
    output logic [SUM_WIDTH-1:0]  checksum_o,
    output logic [CNT_WIDTH-1:0]  frame_cnt_o,
    output logic [ERR_W-1:0]      err_o,
    output logic                  frame_done_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   pix_cnt_q, pix_cnt_d;
    logic [CNT_WIDTH-1:0]   line_cnt_q, line_cnt_d;
    logic [CNT_WIDTH-1:0]   ref_width_q, ref_width_d;
    logic                   first_line_q, first_line_d;
    logic [SUM_WIDTH-1:0]   sum_q, sum_d;
    logic [ERR_W-1:0]       flags_q, flags_d;
    logic [CNT_WIDTH-1:0]   width_q, width_d;
    logic [CNT_WIDTH-1:0]   height_q, height_d;
    logic [SUM_WIDTH-1:0]   checksum_q, checksum_d;
    logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
    logic [ERR_W-1:0]       err_q, err_d;
    logic                   frame_done_q, frame_done_d;

    logic                   in_frame;
    logic                   counted;
    logic                   frame_start;
    logic                   line_end;
    logic                   frame_end;

    // Next-state, counters, accumulators and published results.
    always_comb begin
        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        ref_width_d  = ref_width_q;
        first_line_d = first_line_q;
        sum_d        = sum_q;
        flags_d      = flags_q;
        width_d      = width_q;
        height_d     = height_q;
        checksum_d   = checksum_q;
        frame_cnt_d  = frame_cnt_q;
        err_d        = err_q;
        frame_done_d = 1'b0;
        frame_start  = 1'b0;
        line_end     = 1'b0;
        frame_end    = 1'b0;

        // Every non-sync state either is or is about to enter a line when
        // hs and vs are both low, so that alone decides whether de counts.
        in_frame = (state_q != S_SYNC);
        counted  = in_frame && de_i && !hs_i && !vs_i;

        case (state_q)
            S_SYNC: begin
                if (vs_i) state_d = S_VBLANK;
            end
            S_VBLANK: begin
                if (!vs_i) begin
                    state_d     = hs_i ? S_HBLANK : S_LINE;
                    frame_start = 1'b1;
                end
            end
            S_HBLANK: begin
                if (vs_i) begin
                    state_d   = S_VBLANK;
                    frame_end = 1'b1;
                end else if (!hs_i) begin
                    state_d = S_LINE;
                end
            end
            default: begin // S_LINE
                if (vs_i) begin
                    state_d   = S_VBLANK;
                    line_end  = 1'b1;
                    frame_end = 1'b1;
                end else if (hs_i) begin
                    state_d  = S_HBLANK;
                    line_end = 1'b1;
                end
            end
        endcase

        // Error flags are not cleared at frame start: they are cleared when a
        // frame is published, so de seen during the preceding vblank is
        // charged to the frame that follows it.
        if (frame_start) begin
            pix_cnt_d    = '0;
            line_cnt_d   = '0;
            ref_width_d  = '0;
            first_line_d = 1'b1;
            sum_d        = '0;
        end

        if (counted) begin
            if (pix_cnt_d == CNT_MAX) flags_d[ERR_OVF] = 1'b1;
            else                      pix_cnt_d = pix_cnt_d + CNT_ONE;
            sum_d = sum_d + {{(SUM_WIDTH-DATA_WIDTH){1'b0}}, di_i};
        end

        if (in_frame && de_i && !counted) flags_d[ERR_DE] = 1'b1;

        if (line_end) begin
            if (line_cnt_q == CNT_MAX) flags_d[ERR_OVF] = 1'b1;
            else                       line_cnt_d = line_cnt_q + CNT_ONE;
            if (first_line_q) begin
                ref_width_d  = pix_cnt_q;
                first_line_d = 1'b0;
            end else if (pix_cnt_q != ref_width_q) begin
                flags_d[ERR_WIDTH] = 1'b1;
            end
            pix_cnt_d = '0;
        end

        if (frame_end) begin
            width_d      = ref_width_d;
            height_d     = line_cnt_d;
            checksum_d   = sum_d;
            err_d        = flags_d;
            frame_cnt_d  = frame_cnt_q + CNT_ONE;
            frame_done_d = 1'b1;
            flags_d      = '0;
        end
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_SYNC;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            ref_width_q  <= '0;
            first_line_q <= 1'b0;
            sum_q        <= '0;
            flags_q      <= '0;
            width_q      <= '0;
            height_q     <= '0;
            checksum_q   <= '0;
            frame_cnt_q  <= '0;
            err_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            ref_width_q  <= ref_width_d;
            first_line_q <= first_line_d;
            sum_q        <= sum_d;
            flags_q      <= flags_d;
            width_q      <= width_d;
            height_q     <= height_d;
            checksum_q   <= checksum_d;
            frame_cnt_q  <= frame_cnt_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign width_o      = width_q;
    assign height_o     = height_q;
    assign checksum_o   = checksum_q;
    assign frame_cnt_o  = frame_cnt_q;
    assign err_o        = err_q;
    assign frame_done_o = frame_done_q;

endmodule
